barrido_display: RTL

Scan controller for the 4-digit, 7-segment display. It sits directly upstream of the anode selector and the segment decoder. It holds a 16-bit display value and cycles the 2-bit digit index that drives the anode selector. It also presents the matching nibble and decimal point to the segment decoder, and signals a blanking window and leading-zero suppression. New values are accepted through a load strobe and committed only at frame boundaries, so the displayed value never tears mid-scan.

---
 rtl/barrido_display.sv | 96 +++++++++
 1 files changed

// File: rtl/barrido_display.sv
// Scan controller for a 4-digit 7-segment display: cycles the digit index,
// presents nibble/point, and commits newly loaded values only at frame boundaries.
module barrido_display #(
    parameter int DIV   = 100000,
    parameter int BLANK = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Enable,
    input  logic [15:0] Dato,
    input  logic [3:0]  Punto,
    input  logic        Carga,
    input  logic        ApagarCeros,
    output logic [1:0]  Sel,
    output logic [3:0]  Nibble,
    output logic        PuntoOut,
    output logic        Apagado,
    output logic        Pendiente,
    output logic        Listo
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

    logic [CW-1:0] cnt;
    logic [15:0]   vis, pend;
    logic [3:0]    pvis, ppend;
    logic          tick, boundary;
    logic          lead, lz;

    assign tick     = Enable && (cnt == CNT_MAX);
    assign boundary = tick && (Sel == 2'd3);

    // NOTE: every register here, including the value/point holders, is reset so
    // that an asynchronous reset discards both the displayed and the pending value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            Sel       <= 2'd0;
            vis       <= 16'h0000;
            pvis      <= 4'h0;
            pend      <= 16'h0000;
            ppend     <= 4'h0;
            Pendiente <= 1'b0;
            Listo     <= 1'b0;
        end else begin
            Listo <= 1'b0;

            if (tick) begin
                cnt <= '0;
                Sel <= Sel + 2'd1;
            end else if (Enable) begin
                cnt <= cnt + 1'b1;
            end

            if (boundary && Carga) begin
                // Load on the boundary cycle bypasses the pending stage.
                vis       <= Dato;
                pvis      <= Punto;
                pend      <= Dato;
                ppend     <= Punto;
                Pendiente <= 1'b0;
                Listo     <= 1'b1;
            end else begin
                // A frozen scan cannot tear, so a pending value commits at once.
                if ((boundary || !Enable) && Pendiente) begin
                    vis       <= pend;
                    pvis      <= ppend;
                    Pendiente <= 1'b0;
                    Listo     <= 1'b1;
                end
                if (Carga) begin
                    pend      <= Dato;
                    ppend     <= Punto;
                    Pendiente <= 1'b1;
                end
            end
        end
    end

    // Leading run: every digit from the leftmost down to Sel is zero with no point.
    always_comb begin
        lead = 1'b1;
        for (int i = 1; i < 4; i++) begin
            if (2'(i) >= Sel)
                lead = lead & (vis[4*i +: 4] == 4'h0) & ~pvis[i];
        end
        lz = ApagarCeros & (Sel != 2'd0) & lead;
    end

    assign Nibble   = vis[{Sel, 2'b00} +: 4];
    assign PuntoOut = pvis[Sel];
    assign Apagado  = ~Enable | (cnt < BLANK_C) | lz;

endmodule
